// File: rtl/neuron_cfg_sched.sv
// Round-robin packet scheduler feeding the neuron configuration controller's
// byte-serial input; serialises one accepted request at a time into paced strobes.
module neuron_cfg_sched #(
  parameter int         NUM_REQ          = 2,
  parameter int         GAP_CYCLES       = 1,
  parameter logic [7:0] MODE_SET_CTRL    = 8'h01,
  parameter logic [7:0] MODE_ADDR_WEIGHT = 8'h02,
  parameter logic [7:0] MODE_WEIGHT      = 8'h03,
  parameter logic [7:0] END_PACKET       = 8'hFF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [8*NUM_REQ-1:0]    req_mode,
  input  logic [16*NUM_REQ-1:0]   req_ctrl,
  input  logic [10*NUM_REQ-1:0]   req_addr,
  input  logic [32*NUM_REQ-1:0]   req_value,
  input  logic [NUM_REQ-1:0]      req_flush,
  output logic [7:0]              data,
  output logic                    load_data,
  output logic                    busy,
  output logic [2:0]              grant_id,
  output logic                    pkt_done,
  output logic                    err
);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  // Handshake: a requester raises req_valid[i] with its fields stable and holds
  // them until req_ready[i] pulses; the request is taken at that clock edge.
  typedef enum logic [1:0] {IDLE, STROBE, GAP, DONE} state_t;
  state_t state, state_n;

  logic [2:0]    ptr, sel, cand, grant_q;
  logic          any_valid, accept, supported, err_q;
  logic [7:0]    in_mode, mode_q, last_q, byte_cur;
  logic [15:0]   in_ctrl, ctrl_q;
  logic [9:0]    in_addr, addr_q;
  logic [31:0]   in_value, value_q;
  logic          in_flush, flush_q;
  logic [3:0]    idx, base_len, last_idx;
  logic [1:0]    vi;
  logic [GW-1:0] gap_cnt;
  logic          gap_end;

  // Search starts at the pointer and wraps, so the previous winner goes last.
  always_comb begin
    any_valid = 1'b0;
    sel       = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = 3'((int'(ptr) + k) % NUM_REQ);
      for (int j = 0; j < NUM_REQ; j++)
        if (!any_valid && cand == 3'(j) && req_valid[j]) begin
          any_valid = 1'b1;
          sel       = cand;
        end
    end
  end

  always_comb begin
    in_mode  = '0;
    in_ctrl  = '0;
    in_addr  = '0;
    in_value = '0;
    in_flush = 1'b0;
    for (int j = 0; j < NUM_REQ; j++)
      if (sel == 3'(j)) begin
        in_mode  = req_mode[8*j +: 8];
        in_ctrl  = req_ctrl[16*j +: 16];
        in_addr  = req_addr[10*j +: 10];
        in_value = req_value[32*j +: 32];
        in_flush = req_flush[j];
      end
  end

  assign accept    = (state == IDLE) && any_valid && !rst;
  assign supported = (in_mode == MODE_SET_CTRL) || (in_mode == MODE_ADDR_WEIGHT) ||
                     (in_mode == MODE_WEIGHT);

  always_comb begin
    req_ready = '0;
    for (int j = 0; j < NUM_REQ; j++)
      req_ready[j] = accept && (sel == 3'(j));
  end

  assign base_len = (mode_q == MODE_SET_CTRL) ? 4'd3 : (mode_q == MODE_WEIGHT) ? 4'd7 : 4'd9;
  assign last_idx = base_len + {3'b000, flush_q} - 4'd1;
  assign vi       = (mode_q == MODE_WEIGHT) ? 2'(idx - 4'd3) : 2'(idx - 4'd5);

  always_comb begin
    byte_cur = END_PACKET;
    if (idx == 4'd0)                                  byte_cur = mode_q;
    else if (idx == 4'd1)                             byte_cur = ctrl_q[7:0];
    else if (idx == 4'd2)                             byte_cur = ctrl_q[15:8];
    else if (idx >= base_len)                         byte_cur = END_PACKET;
    else if (mode_q == MODE_ADDR_WEIGHT && idx == 4'd3) byte_cur = addr_q[7:0];
    else if (mode_q == MODE_ADDR_WEIGHT && idx == 4'd4) byte_cur = {6'b0, addr_q[9:8]};
    else                                              byte_cur = value_q[{vi, 3'b000} +: 8];
  end

  assign gap_end = (gap_cnt == GW'(GAP_CYCLES - 1));

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept && supported) state_n = STROBE;
      STROBE:  state_n = GAP;
      GAP:     if (gap_end) state_n = (idx == last_idx) ? DONE : STROBE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      ptr     <= '0;
      grant_q <= '0;
      err_q   <= 1'b0;
      idx     <= '0;
      gap_cnt <= '0;
      last_q  <= '0;
      mode_q  <= '0;
      ctrl_q  <= '0;
      addr_q  <= '0;
      value_q <= '0;
      flush_q <= 1'b0;
    end else begin
      state <= state_n;
      err_q <= accept && !supported;
      if (accept) begin
        mode_q  <= in_mode;
        ctrl_q  <= in_ctrl;
        addr_q  <= in_addr;
        value_q <= in_value;
        flush_q <= in_flush;
        grant_q <= sel;
        idx     <= '0;
        ptr     <= (sel == 3'(NUM_REQ - 1)) ? 3'd0 : sel + 3'd1;
      end
      if (state == STROBE) begin
        last_q  <= byte_cur;
        gap_cnt <= '0;
      end
      if (state == GAP) begin
        gap_cnt <= gap_cnt + GW'(1);
        if (gap_end) idx <= idx + 4'd1;
      end
    end
  end

  // The byte under transmission is shown through its gap; afterwards the last byte is held.
  assign data      = (state == STROBE || state == GAP) ? byte_cur : last_q;
  assign load_data = (state == STROBE);
  assign busy      = (state == STROBE) || (state == GAP);
  assign pkt_done  = (state == DONE);
  assign grant_id  = grant_q;
  assign err       = err_q;
endmodule

// File: tb/tb_neuron_cfg_sched.sv
// Bench for neuron_cfg_sched: two instances (gap 1 and gap 3), a negedge monitor,
// and a byte-list reference model built from the packet format rules.
module tb_neuron_cfg_sched;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [1:0]  req_valid, req_valid3, req_flush;
  logic [15:0] req_mode;
  logic [31:0] req_ctrl;
  logic [19:0] req_addr;
  logic [63:0] req_value;

  logic [1:0] ready1, ready3;
  logic [7:0] data1, data3;
  logic       ld1, busy1, done1, err1, ld3, busy3, done3, err3;
  logic [2:0] gid1, gid3;

  neuron_cfg_sched #(.NUM_REQ(2), .GAP_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready1),
    .req_mode(req_mode), .req_ctrl(req_ctrl), .req_addr(req_addr),
    .req_value(req_value), .req_flush(req_flush), .data(data1),
    .load_data(ld1), .busy(busy1), .grant_id(gid1), .pkt_done(done1), .err(err1));

  neuron_cfg_sched #(.NUM_REQ(2), .GAP_CYCLES(3)) u3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(ready3),
    .req_mode(req_mode), .req_ctrl(req_ctrl), .req_addr(req_addr),
    .req_value(req_value), .req_flush(req_flush), .data(data3),
    .load_data(ld3), .busy(busy3), .grant_id(gid3), .pkt_done(done3), .err(err3));

  int checks = 0;
  int errors = 0;

  // Observation queues filled by the monitor.
  int         acc_t[$], st_t[$], done_t[$], err_t[$];
  logic [1:0] acc_v[$];
  logic [7:0] st_b[$];
  logic [2:0] st_g[$];
  int         st3_t[$], done3_t[$];
  logic [7:0] st3_b[$];
  int         gap_bad, gap_bad3, busy_cyc, orphan;
  logic [7:0] last1, last3;
  logic [7:0] exp_q[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (|ready1) begin acc_t.push_back(cyc); acc_v.push_back(ready1); end
      if (ld1) begin
        st_t.push_back(cyc); st_b.push_back(data1); st_g.push_back(gid1);
        last1 = data1;
        if (!busy1) orphan++;
      end else if (busy1 && data1 !== last1) gap_bad++;
      if (busy1) busy_cyc++;
      if (done1) done_t.push_back(cyc);
      if (err1) err_t.push_back(cyc);
      if (ld3) begin st3_t.push_back(cyc); st3_b.push_back(data3); last3 = data3; end
      else if (busy3 && data3 !== last3) gap_bad3++;
      if (done3) done3_t.push_back(cyc);
    end
  end

  task automatic clear_obs();
    acc_t.delete(); acc_v.delete(); st_t.delete(); st_b.delete(); st_g.delete();
    done_t.delete(); err_t.delete(); st3_t.delete(); st3_b.delete(); done3_t.delete();
    exp_q.delete();
    gap_bad = 0; gap_bad3 = 0; busy_cyc = 0; orphan = 0;
  endtask

  // Reference packet: header, optional address, optional value (LSB first), optional terminator.
  task automatic model_push(input logic [7:0] mode, input logic [15:0] ctrl,
                            input logic [9:0] addr, input logic [31:0] value, input logic flush);
    exp_q.push_back(mode);
    exp_q.push_back(ctrl[7:0]);
    exp_q.push_back(ctrl[15:8]);
    if (mode == 8'h02) begin
      exp_q.push_back(addr[7:0]);
      exp_q.push_back({6'b0, addr[9:8]});
    end
    if (mode == 8'h02 || mode == 8'h03)
      for (int k = 0; k < 4; k++) exp_q.push_back(value[8*k +: 8]);
    if (flush) exp_q.push_back(8'hFF);
  endtask

  task automatic set_req(input int i, input logic [7:0] mode, input logic [15:0] ctrl,
                         input logic [9:0] addr, input logic [31:0] value, input logic flush);
    req_mode[8*i +: 8]   = mode;
    req_ctrl[16*i +: 16] = ctrl;
    req_addr[10*i +: 10] = addr;
    req_value[32*i +: 32] = value;
    req_flush[i]         = flush;
  endtask

  // Drives u1 until n accepts are seen; keep=0 drops each winner after its accept.
  task automatic arb_run(input bit keep, input int n);
    int got = 0;
    logic [1:0] r;
    for (int c = 0; c < 400 && got < n; c++) begin
      @(negedge clk); #1;
      r = ready1;
      if (|r) got++;
      @(posedge clk); #1;
      if (!keep) req_valid = req_valid & ~r;
      if (got == n) req_valid = 2'b00;
    end
    if (got < n) begin
      errors++;
      $display("FAIL accept_timeout: got %0d accepts, required %0d", got, n);
      req_valid = 2'b00;
    end
  endtask

  task automatic wait_done(input int n);
    int c = 0;
    while (done_t.size() < n && c < 600) begin @(negedge clk); #1; c++; end
    checks++;
    if (done_t.size() < n) begin
      errors++;
      $display("FAIL done_timeout: got %0d pkt_done, required %0d", done_t.size(), n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if ({ready1, data1, ld1, busy1, gid1, done1, err1} !== '0) begin
      errors++;
      $display("FAIL reset_u1: outputs %h, required 0",
               {ready1, data1, ld1, busy1, gid1, done1, err1});
    end
    checks++;
    if ({ready3, data3, ld3, busy3, gid3, done3, err3} !== '0) begin
      errors++;
      $display("FAIL reset_u3: outputs %h, required 0",
               {ready3, data3, ld3, busy3, gid3, done3, err3});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_set_ctrl();
    clear_obs();
    set_req(0, 8'h01, 16'h012A, 10'h0, 32'h0, 1'b0);
    model_push(8'h01, 16'h012A, 10'h0, 32'h0, 1'b0);
    req_valid = 2'b01;
    arb_run(0, 1);
    wait_done(1);
    checks++;
    if (st_b.size() != 3) begin
      errors++; $display("FAIL setctrl_count: got %0d strobes, required 3", st_b.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (st_b[k] !== exp_q[k] || st_t[k] != acc_t[0] + 1 + 2*k) begin
          errors++;
          $display("FAIL setctrl_byte%0d: got %h at t+%0d, required %h at t+%0d",
                   k, st_b[k], st_t[k] - acc_t[0], exp_q[k], 1 + 2*k);
        end
      end
    end
    checks++;
    if (done_t[0] != acc_t[0] + 7 || busy_cyc != 6) begin
      errors++;
      $display("FAIL setctrl_timing: done at t+%0d busy %0d cycles, required t+7 and 6",
               done_t[0] - acc_t[0], busy_cyc);
    end
  endtask

  task automatic test_addr_weight();
    clear_obs();
    set_req(1, 8'h02, 16'h0055, 10'h2C5, 32'hDEADBEEF, 1'b1);
    model_push(8'h02, 16'h0055, 10'h2C5, 32'hDEADBEEF, 1'b1);
    req_valid = 2'b10;
    arb_run(0, 1);
    wait_done(1);
    checks++;
    if (st_b.size() != 10) begin
      errors++; $display("FAIL aw_count: got %0d strobes, required 10", st_b.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        checks++;
        if (st_b[k] !== exp_q[k] || st_g[k] !== 3'd1) begin
          errors++;
          $display("FAIL aw_byte%0d: got %h grant %0d, required %h grant 1",
                   k, st_b[k], st_g[k], exp_q[k]);
        end
      end
    end
    checks++;
    if (gap_bad != 0 || orphan != 0) begin
      errors++;
      $display("FAIL aw_gap: %0d unstable gap cycles %0d stray strobes, required 0", gap_bad, orphan);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    clear_obs();
    set_req(0, 8'h01, 16'h0011, 10'h0, 32'h0, 1'b0);
    set_req(1, 8'h01, 16'h0022, 10'h0, 32'h0, 1'b0);
    for (int g = 0; g < 4; g++)
      model_push(8'h01, (g % 2 == 0) ? 16'h0011 : 16'h0022, 10'h0, 32'h0, 1'b0);
    req_valid = 2'b11;
    arb_run(1, 4);
    wait_done(4);
    checks++;
    if (acc_v.size() != 4 || st_b.size() != 12) begin
      errors++;
      $display("FAIL rr_count: got %0d accepts %0d strobes, required 4 and 12", acc_v.size(), st_b.size());
    end else begin
      for (int g = 0; g < 4; g++) begin
        exp_g = (g % 2 == 0) ? 2'b01 : 2'b10;
        checks++;
        if (acc_v[g] !== exp_g || (g > 0 && acc_t[g] - acc_t[g-1] < 2)) begin
          errors++;
          $display("FAIL rr_grant%0d: got ready %b at %0d, required %b as a single pulse",
                   g, acc_v[g], acc_t[g], exp_g);
        end
      end
      for (int k = 0; k < 12; k++) begin
        checks++;
        if (st_b[k] !== exp_q[k] || (k > 0 && st_t[k] - st_t[k-1] < 2)) begin
          errors++;
          $display("FAIL rr_byte%0d: got %h at %0d, required %h spaced by 2 or more",
                   k, st_b[k], st_t[k], exp_q[k]);
        end
      end
    end
  endtask

  task automatic test_bad_opcode();
    clear_obs();
    set_req(0, 8'h07, 16'h1234, 10'h0, 32'h0, 1'b1);
    set_req(1, 8'h01, 16'h0033, 10'h0, 32'h0, 1'b0);
    model_push(8'h01, 16'h0033, 10'h0, 32'h0, 1'b0);
    req_valid = 2'b11;
    arb_run(0, 2);
    wait_done(1);
    checks++;
    if (acc_v.size() != 2 || err_t.size() != 1) begin
      errors++;
      $display("FAIL err_count: got %0d accepts %0d err pulses, required 2 and 1", acc_v.size(), err_t.size());
    end else begin
      checks++;
      if (acc_v[0] !== 2'b01 || acc_v[1] !== 2'b10 || err_t[0] != acc_t[0] + 1) begin
        errors++;
        $display("FAIL err_seq: got ready %b,%b err at t+%0d, required 01,10 err at t+1",
                 acc_v[0], acc_v[1], err_t[0] - acc_t[0]);
      end
      checks++;
      if (st_b.size() != 3 || st_t[0] != acc_t[1] + 1 || st_b[0] !== exp_q[0] || st_b[1] !== exp_q[1]) begin
        errors++;
        $display("FAIL err_tx: got %0d strobes first %h, required 3 strobes of req1 only",
                 st_b.size(), st_b[0]);
      end
    end
  endtask

  task automatic test_gap3();
    int c = 0;
    clear_obs();
    set_req(0, 8'h03, 16'h0107, 10'h0, 32'h00000100, 1'b0);
    model_push(8'h03, 16'h0107, 10'h0, 32'h00000100, 1'b0);
    req_valid3 = 2'b01;
    while (!ready3[0] && c < 50) begin @(negedge clk); #1; c++; end
    @(posedge clk); #1;
    req_valid3 = 2'b00;
    c = 0;
    while (done3_t.size() < 1 && c < 200) begin @(negedge clk); #1; c++; end
    checks++;
    if (st3_b.size() != 7 || done3_t.size() != 1) begin
      errors++;
      $display("FAIL gap3_count: got %0d strobes %0d done, required 7 and 1", st3_b.size(), done3_t.size());
    end else begin
      for (int k = 0; k < 7; k++) begin
        checks++;
        if (st3_b[k] !== exp_q[k] || (k > 0 && st3_t[k] - st3_t[k-1] != 4)) begin
          errors++;
          $display("FAIL gap3_byte%0d: got %h at %0d, required %h spaced by 4", k, st3_b[k], st3_t[k], exp_q[k]);
        end
      end
      checks++;
      if (done3_t[0] != st3_t[6] + 4 || gap_bad3 != 0) begin
        errors++;
        $display("FAIL gap3_done: got done %0d after last strobe, %0d unstable, required 4 and 0",
                 done3_t[0] - st3_t[6], gap_bad3);
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] mode;
    logic [15:0] ctrl;
    logic [9:0] addr;
    logic [31:0] value;
    logic flush;
    int i, sel;
    for (int n = 0; n < 24; n++) begin
      clear_obs();
      i = $urandom_range(0, 1);
      sel = $urandom_range(1, 3);
      mode = 8'(sel);
      ctrl = 16'($urandom); addr = 10'($urandom); value = $urandom; flush = 1'($urandom);
      set_req(i, mode, ctrl, addr, value, flush);
      model_push(mode, ctrl, addr, value, flush);
      req_valid = (i == 0) ? 2'b01 : 2'b10;
      arb_run(0, 1);
      wait_done(1);
      checks++;
      if (st_b.size() != exp_q.size() || orphan != 0 || gap_bad != 0) begin
        errors++;
        $display("FAIL rand%0d_count: got %0d strobes, required %0d (mode %h flush %b)",
                 n, st_b.size(), exp_q.size(), mode, flush);
      end else begin
        for (int k = 0; k < exp_q.size(); k++) begin
          checks++;
          if (st_b[k] !== exp_q[k] || st_t[k] != acc_t[0] + 1 + 2*k || st_g[k] !== 3'(i)) begin
            errors++;
            $display("FAIL rand%0d_byte%0d: got %h t+%0d grant %0d, required %h t+%0d grant %0d",
                     n, k, st_b[k], st_t[k] - acc_t[0], st_g[k], exp_q[k], 1 + 2*k, i);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int c = 0;
    clear_obs();
    set_req(0, 8'h02, 16'h00AA, 10'h155, 32'h12345678, 1'b1);
    req_valid = 2'b01;
    arb_run(0, 1);
    while (st_b.size() < 4 && c < 50) begin @(negedge clk); #1; c++; end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    checks++;
    if ({ready1, data1, ld1, busy1, gid1, done1, err1} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got %h, required 0", {ready1, data1, ld1, busy1, gid1, done1, err1});
    end
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (st_b.size() != 4 || done_t.size() != 0) begin
      errors++;
      $display("FAIL midrst_abort: got %0d strobes %0d done, required 4 and 0", st_b.size(), done_t.size());
    end
    clear_obs();
    set_req(0, 8'h01, 16'h0044, 10'h0, 32'h0, 1'b0);
    set_req(1, 8'h02, 16'h0066, 10'h3A1, 32'hCAFEF00D, 1'b1);
    model_push(8'h01, 16'h0044, 10'h0, 32'h0, 1'b0);
    model_push(8'h02, 16'h0066, 10'h3A1, 32'hCAFEF00D, 1'b1);
    req_valid = 2'b11;
    arb_run(0, 2);
    wait_done(2);
    checks++;
    if (acc_v.size() != 2 || acc_v[0] !== 2'b01 || st_b.size() != exp_q.size()) begin
      errors++;
      $display("FAIL midrst_ptr: got first ready %b and %0d strobes, required 01 and %0d",
               acc_v[0], st_b.size(), exp_q.size());
    end else begin
      for (int k = 0; k < exp_q.size(); k++) begin
        checks++;
        if (st_b[k] !== exp_q[k]) begin
          errors++;
          $display("FAIL midrst_byte%0d: got %h, required %h", k, st_b[k], exp_q[k]);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0; req_valid3 = '0; req_flush = '0;
    req_mode = '0; req_ctrl = '0; req_addr = '0; req_value = '0;
    last1 = '0; last3 = '0;
    clear_obs();
    test_reset();
    test_set_ctrl();
    test_addr_weight();
    test_round_robin();
    test_bad_opcode();
    test_gap3();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/neuron_cfg_sched.md
Name: neuron_cfg_sched

Overview:
Packet scheduler and arbiter in front of the neuron configuration controller's byte-serial input (data, load_data). It accepts complete configuration requests from NUM_REQ requesters, for example the RISC-V MMIO bridge and the on-chip learning unit. It arbitrates among them round-robin and serialises each winning request into the controller's byte protocol: mode byte, two control bytes, optional address bytes, optional value bytes, optional END_PACKET. It paces strobes so that the controller samples exactly one byte per strobe.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
GAP_CYCLES, 1, idle cycles after each strobe before the next byte (>=1)
MODE_SET_CTRL, 8'h01, opcode: control signals only
MODE_ADDR_WEIGHT, 8'h02, opcode: control + address + value
MODE_WEIGHT, 8'h03, opcode: control + value at current address
END_PACKET, 8'hFF, terminator byte that triggers the neuron load

Ports:
clk  in  1  clock; already decided
rst  in  1  synchronous, active-high reset; already decided
req_valid  in  NUM_REQ  request i valid; held until accepted
req_ready  out  NUM_REQ  one-hot accept pulse
req_mode  in  8*NUM_REQ  opcode of request i
req_ctrl  in  16*NUM_REQ  [7:0] ctrl byte 0 {adder_model,init_mode_adder,decay_mode}; [15:8] ctrl byte 1 (bit0 init_mode_acc)
req_addr  in  10*NUM_REQ  neuron/weight address
req_value  in  32*NUM_REQ  weight/parameter value
req_flush  in  NUM_REQ  append END_PACKET after the packet
data  out  8  byte to the controller
load_data  out  1  byte strobe, one cycle high
busy  out  1  high from accept through the last gap cycle
grant_id  out  3  index of the request being sent; valid while busy
pkt_done  out  1  one-cycle pulse after the final gap of a packet
err  out  1  one-cycle pulse when an unsupported opcode is dropped

Behaviour:
- Reset values: req_ready=0, data=0, load_data=0, busy=0, grant_id=0, pkt_done=0, err=0, round-robin pointer=0, FSM=IDLE.
- Reset mid-packet: all outputs return to reset values at the next edge and the packet is discarded. No END_PACKET is emitted.
- FSM states: IDLE, STROBE, GAP, DONE.
- IDLE: if any req_valid, pick the first valid index at or after the pointer, wrapping modulo NUM_REQ.
  - req_ready[i] is asserted combinationally in the same cycle.
  - mode/ctrl/addr/value/flush are captured into shadow registers at that edge.
  - Pointer becomes (i+1) mod NUM_REQ.
  - Next state: STROBE with byte index 0, busy=1, grant_id=i.
- Unsupported opcode: the request is still accepted (req_ready pulses). err pulses on the following cycle and the FSM stays in IDLE. Nothing is transmitted and the pointer still advances.
- Byte sequences (value bytes go LSB first):
  - MODE_SET_CTRL: mode, c0, c1 (3 bytes).
  - MODE_WEIGHT: mode, c0, c1, v[7:0], v[15:8], v[23:16], v[31:24] (7 bytes).
  - MODE_ADDR_WEIGHT: mode, c0, c1, addr[7:0], {6'b0,addr[9:8]}, then the 4 value bytes (9 bytes).
  - If flush is set, END_PACKET is appended as a final byte.
- STROBE: data=current byte and load_data=1 for exactly one cycle, then GAP.
- GAP: load_data=0 and data is held at the last byte for GAP_CYCLES cycles. Then go to STROBE with the next byte, or to DONE if no bytes remain.
- Strobe spacing is therefore 1+GAP_CYCLES cycles, and the first strobe occurs in the cycle after accept.
- DONE: pkt_done=1 for one cycle, busy=0, return to IDLE. A new accept can occur in the cycle after DONE.
- data holds its last value in IDLE (it is not cleared), except at reset.
- Requests arriving while busy wait; at most one packet is in flight.
- Simultaneous valids are resolved only by the round-robin pointer.
- Deasserting req_valid before acceptance is a protocol violation with no defined result.

Test Plan:
- GAP=1. Req0: SET_CTRL, ctrl=16'h012A, no flush, accepted at t -> strobes at t+1, t+3, t+5 with bytes 01, 2A, 01; pkt_done at t+7; busy high t+1..t+6.
- Req1: ADDR_WEIGHT, ctrl=16'h0055, addr=10'h2C5, value=32'hDEADBEEF, flush=1 -> bytes 02, 55, 00, C5, 02, EF, BE, AD, DE, FF (10 strobes); grant_id=1.
- Both requesters held valid continuously with SET_CTRL -> grants alternate 0, 1, 0, 1; each req_ready is a single-cycle pulse; no strobes overlap.
- Req0 with mode 8'h07 -> req_ready[0] pulses; err pulses the next cycle; no load_data; next grant goes to req1 if valid.
- GAP=3, WEIGHT, value 32'h00000100 -> strobe spacing of 4 cycles; data is stable through each gap; bytes 03, c0, c1, 00, 01, 00, 00.
- rst asserted after the 4th strobe of an ADDR_WEIGHT packet -> all outputs are zero at the next edge; pointer=0; after release, a fresh req1 packet transmits complete.
